mmu: RTL and testbench

- Page-granular (4 KiB) address translator between the 68000 CPU and the physical bus.
- Maps the 24-bit CPU address space (page bits 23:12) onto a 28-bit physical space (page bits 27:12).
- User-mode accesses use an external page-table RAM indexed by task number and virtual page.
- Supervisor accesses use a fixed region decode with two bank-select registers supplied by the glue logic.
- A clocked fault-capture block records the first illegal access for the kernel.

---
 rtl/mmu_if.sv | 33 +++
 rtl/mmu.sv | 121 ++++++++++++
 tb/tb_mmu.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mmu_if.sv
// CPU-side and page-table-side signal bundle for the mmu.
// The tri-state physical page output stays a plain port on the mmu so
// that its high-impedance state reaches the physical bus unchanged.
interface mmu_if;
   logic        enable;
   logic [11:0] addr_in;
   logic [2:0]  fc;
   logic [3:0]  user_map;
   logic [7:0]  supervisor_map_1;
   logic [7:0]  supervisor_map_2;
   logic [15:0] table_ram_addr_bus;
   logic [15:0] table_ram_data_bus;
   logic        fault;
   logic        fault_latched;
   logic [14:0] fault_info;
   logic        fault_clear;

   // The mmu itself
   modport slave (
      input  enable, addr_in, fc, user_map,
      input  supervisor_map_1, supervisor_map_2,
      input  table_ram_data_bus, fault_clear,
      output table_ram_addr_bus, fault, fault_latched, fault_info
   );

   // CPU, glue logic and page-table RAM driving the mmu
   modport master (
      output enable, addr_in, fc, user_map,
      output supervisor_map_1, supervisor_map_2,
      output table_ram_data_bus, fault_clear,
      input  table_ram_addr_bus, fault, fault_latched, fault_info
   );
endinterface

// File: rtl/mmu.sv
// 68000 page translator: 24-bit virtual (4 KiB pages) to 28-bit physical.
// User accesses go through an external page table indexed by
// {task, virtual page}; supervisor accesses use a fixed region decode with
// two bank registers. Translation is purely combinational; only the
// first-fault capture is clocked.
module mmu (
   input  logic       clk,
   input  logic       reset_n,
   mmu_if.slave       bus,
   output tri  [15:0] addr_out
);

   localparam logic [2:0] FC_USER_DATA = 3'b001;
   localparam logic [2:0] FC_USER_PROG = 3'b010;
   localparam logic [2:0] FC_SUPV_DATA = 3'b101;
   localparam logic [2:0] FC_SUPV_PROG = 3'b110;
   localparam logic [2:0] FC_CPU_SPACE = 3'b111;

   typedef enum logic [2:0] {
      REGION_RAM,
      REGION_ROM,
      REGION_IO,
      REGION_HOLE,
      REGION_GFX
   } region_t;

   // Supervisor address map, keyed on the top bits of the virtual page.
   function automatic region_t supv_region(input logic [11:0] page);
      region_t r;
      case (page[11:10])
         2'b00:   r = REGION_RAM;
         2'b01:   r = REGION_ROM;
         2'b10:   r = (page[9:8] == 2'b00) ? REGION_IO : REGION_HOLE;
         default: r = REGION_GFX;
      endcase
      return r;
   endfunction

   // Physical page for a supervisor region; the hole maps to page 0.
   function automatic logic [15:0] supv_phys(input region_t     r,
                                             input logic [11:0] page,
                                             input logic [3:0]  ram_bank,
                                             input logic [3:0]  rom_bank);
      logic [15:0] p;
      case (r)
         REGION_RAM: p = {2'b10, ram_bank, page[9:0]};
         REGION_ROM: p = {2'b01, rom_bank, page[9:0]};
         REGION_IO:  p = {8'h03, page[7:0]};
         REGION_GFX: p = {4'b0011, page};
         default:    p = 16'h0000;
      endcase
      return p;
   endfunction

   logic [15:0] phys;
   logic [15:0] table_addr;
   logic        fault_now;
   logic        drive;
   region_t     region;

   // Bank-select upper nibbles are reserved and deliberately ignored.
   logic        unused_bank_bits;
   assign unused_bank_bits = ^{bus.supervisor_map_1[7:4], bus.supervisor_map_2[7:4]};

   // Translation decode: function code picks the path, address picks the page.
   always_comb begin
      phys       = 16'h0000;
      table_addr = 16'h0000;
      fault_now  = 1'b0;
      drive      = 1'b0;
      region     = supv_region(bus.addr_in);
      if (bus.enable) begin
         drive = 1'b1;
         case (bus.fc)
            FC_USER_DATA, FC_USER_PROG: begin
               table_addr = {bus.user_map, bus.addr_in};
               phys       = bus.table_ram_data_bus;
            end
            FC_SUPV_DATA, FC_SUPV_PROG: begin
               phys      = supv_phys(region, bus.addr_in,
                                     bus.supervisor_map_1[3:0],
                                     bus.supervisor_map_2[3:0]);
               fault_now = (region == REGION_HOLE);
            end
            FC_CPU_SPACE: begin
               // Interrupt acknowledge: drive page 0, no table lookup.
               phys = 16'h0000;
            end
            default: begin
               // Reserved function codes are illegal.
               fault_now = 1'b1;
            end
         endcase
      end
   end

   assign addr_out               = drive ? phys : 16'hzzzz;
   assign bus.table_ram_addr_bus = table_addr;
   assign bus.fault              = fault_now;

   logic        latched;
   logic [14:0] info;

   // First-fault capture: clear has priority, later faults never overwrite.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         latched <= 1'b0;
         info    <= 15'h0000;
      end else if (bus.fault_clear) begin
         latched <= 1'b0;
         info    <= 15'h0000;
      end else if (fault_now && !latched) begin
         latched <= 1'b1;
         info    <= {bus.fc, bus.addr_in};
      end
   end

   assign bus.fault_latched = latched;
   assign bus.fault_info    = info;

endmodule

// File: tb/tb_mmu.sv
// Bench for mmu: directed steps from the test plan followed by random
// traffic, all compared against a behavioural translation model.
// addr_out is observed through a pulled-up net, so "not driven" reads as
// all ones.
module tb_mmu;
   logic clk = 1'b0;
   logic reset_n;
   tri1 [15:0] addr_out;

   mmu_if bus();

   mmu dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .addr_out (addr_out)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic        m_latched;
   logic [14:0] m_info;

   // Behavioural translation model, written from the address map ranges.
   function automatic void ref_xlate(input logic en, input logic [2:0] f,
                                     input logic [11:0] a, input logic [3:0] um,
                                     input logic [7:0] s1, input logic [7:0] s2,
                                     input logic [15:0] data,
                                     output logic [15:0] o, output logic [15:0] ra,
                                     output logic flt);
      int unsigned page;
      int unsigned ram_bank;
      int unsigned rom_bank;
      page     = a;
      ram_bank = s1 % 16;
      rom_bank = s2 % 16;
      o   = 16'hFFFF;
      ra  = 16'h0000;
      flt = 1'b0;
      if (en) begin
         o = 16'h0000;
         if (f == 3'd1 || f == 3'd2) begin
            ra = 16'(um * 4096 + page);
            o  = data;
         end else if (f == 3'd5 || f == 3'd6) begin
            if (page < 1024)        o = 16'(32'h8000 + ram_bank * 1024 + page);
            else if (page < 2048)   o = 16'(32'h4000 + rom_bank * 1024 + (page - 1024));
            else if (page < 'h900)  o = 16'(32'h0300 + (page - 'h800));
            else if (page < 'hC00)  flt = 1'b1;
            else                    o = 16'(32'h3000 + page);
         end else if (f != 3'd7) begin
            flt = 1'b1;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // One stimulus step: apply inputs, check the combinational result,
   // then take one clock edge and check the fault capture.
   task automatic step(input string tag, input logic en, input logic [2:0] f,
                       input logic [11:0] a, input logic [3:0] um,
                       input logic [7:0] s1, input logic [7:0] s2,
                       input logic [15:0] data, input logic clr);
      logic [15:0] eo;
      logic [15:0] era;
      logic        ef;
      bus.enable             = en;
      bus.fc                 = f;
      bus.addr_in            = a;
      bus.user_map           = um;
      bus.supervisor_map_1   = s1;
      bus.supervisor_map_2   = s2;
      bus.table_ram_data_bus = data;
      bus.fault_clear        = clr;
      #1;
      ref_xlate(en, f, a, um, s1, s2, data, eo, era, ef);
      check({tag, ".addr_out"}, addr_out, eo);
      check({tag, ".ram_addr"}, bus.table_ram_addr_bus, era);
      check({tag, ".fault"}, {15'b0, bus.fault}, {15'b0, ef});
      @(posedge clk);
      #1;
      if (clr) begin
         m_latched = 1'b0;
         m_info    = 15'h0000;
      end else if (ef && !m_latched) begin
         m_latched = 1'b1;
         m_info    = {f, a};
      end
      check({tag, ".latched"}, {15'b0, bus.fault_latched}, {15'b0, m_latched});
      check({tag, ".info"}, {1'b0, bus.fault_info}, {1'b0, m_info});
   endtask

   initial begin
      logic [11:0] ram_pages [4] = '{12'h000, 12'h001, 12'h3FE, 12'h3FF};
      logic [11:0] rom_pages [4] = '{12'h400, 12'h401, 12'h7FE, 12'h7FF};
      logic [11:0] gfx_pages [4] = '{12'hC00, 12'hC01, 12'hF0E, 12'hFFF};
      logic [11:0] io_pages  [4] = '{12'h800, 12'h801, 12'h8FE, 12'h8FF};
      logic [11:0] lk_addr   [5] = '{12'h000, 12'h000, 12'h002, 12'h002, 12'h002};
      logic [3:0]  lk_map    [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd4};

      reset_n                = 1'b0;
      bus.enable             = 1'b0;
      bus.fc                 = 3'b000;
      bus.addr_in            = 12'h000;
      bus.user_map           = 4'h0;
      bus.supervisor_map_1   = 8'h00;
      bus.supervisor_map_2   = 8'h00;
      bus.table_ram_data_bus = 16'h0000;
      bus.fault_clear        = 1'b0;
      m_latched              = 1'b0;
      m_info                 = 15'h0000;
      #2;
      check("reset.latched", {15'b0, bus.fault_latched}, 16'h0000);
      check("reset.info", {1'b0, bus.fault_info}, 16'h0000);
      check("reset.addr_out_z", addr_out, 16'hFFFF);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // User data bus and release
      step("user_data", 1'b1, 3'b001, 12'h000, 4'h0, 8'h00, 8'h00, 16'h0002, 1'b0);
      step("user_off", 1'b0, 3'b001, 12'h000, 4'h0, 8'h00, 8'h00, 16'h0002, 1'b0);

      // User table lookups
      foreach (lk_addr[i])
         step("user_lookup", 1'b1, 3'b010, lk_addr[i], lk_map[i], 8'h00, 8'h00, 16'hBEEF, 1'b0);

      // Supervisor RAM / ROM / graphics / primary I/O
      foreach (ram_pages[i])
         step("supv_ram", 1'b1, 3'b101, ram_pages[i], 4'h0, 8'h00, 8'h00, 16'h1234, 1'b0);
      foreach (rom_pages[i])
         step("supv_rom", 1'b1, 3'b110, rom_pages[i], 4'h0, 8'h00, 8'h00, 16'h1234, 1'b0);
      step("supv_bank", 1'b1, 3'b101, 12'h005, 4'h0, 8'hF3, 8'hA5, 16'h0000, 1'b0);
      check("supv_bank.const", addr_out, 16'h8C05);
      foreach (gfx_pages[i])
         step("supv_gfx", 1'b1, 3'b101, gfx_pages[i], 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);
      foreach (io_pages[i])
         step("supv_io", 1'b1, 3'b110, io_pages[i], 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);
      step("cpu_space", 1'b1, 3'b111, 12'h9A0, 4'h3, 8'h00, 8'h00, 16'h5555, 1'b0);

      // Fault capture: first fault sticks, second does not overwrite
      step("fault_hole", 1'b1, 3'b101, 12'h9A0, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);
      check("fault_hole.info_const", {1'b0, bus.fault_info}, 16'h59A0);
      step("fault_resv", 1'b1, 3'b000, 12'h123, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);
      check("fault_resv.info_const", {1'b0, bus.fault_info}, 16'h59A0);
      step("fault_clear_wins", 1'b1, 3'b100, 12'hABC, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b1);
      check("fault_clear.latched_const", {15'b0, bus.fault_latched}, 16'h0000);
      step("fault_again", 1'b1, 3'b011, 12'h777, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b0);

      // Asynchronous reset between clock edges
      bus.enable = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      m_latched = 1'b0;
      m_info    = 15'h0000;
      check("async_reset.latched", {15'b0, bus.fault_latched}, 16'h0000);
      check("async_reset.info", {1'b0, bus.fault_info}, 16'h0000);
      #1;
      reset_n = 1'b1;

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         step("random",
              ($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)),
              12'($urandom),
              4'($urandom),
              8'($urandom),
              8'($urandom),
              16'($urandom),
              ($urandom_range(0, 15) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Overall time bound so the run always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
